// File: rtl/hs32_decode_q.sv
// HS32 decode stage: cracks the 4-bit format prefix of each accepted word into a
// uniform bundle and buffers the bundles in a DEPTH-entry queue toward execute.
module hs32_decode_q #(
  parameter int DEPTH     = 2,
  parameter bit IMM_SEXT  = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instd,
  input  logic                 ackd,
  output logic                 reqd,
  input  logic                 flush,
  output logic                 dvalid,
  input  logic                 dready,
  output logic [2:0]           fmt,
  output logic [3:0]           aluop,
  output logic [3:0]           regdst,
  output logic [3:0]           regsrc,
  output logic [3:0]           regopd,
  output logic [4:0]           shift,
  output logic [31:0]          imm,
  output logic [11:0]          ctlsig,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] ndecoded
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];

  typedef struct packed {
    logic [2:0]  fmt;
    logic [3:0]  aluop;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic [11:0] ctl;
    logic        illegal;
  } bundle_t;

  function automatic logic [31:0] ext16(input logic [15:0] v);
    return IMM_SEXT ? {{16{v[15]}}, v} : {16'h0000, v};
  endfunction

  function automatic logic [31:0] ext24(input logic [23:0] v);
    return IMM_SEXT ? {{8{v[23]}}, v} : {8'h00, v};
  endfunction

  function automatic bundle_t decode(input logic [31:0] w);
    bundle_t b;
    // NOTE: default every field first so unlisted fields read 0 and no branch leaves a hole.
    b = '0;
    case (w[31:28])
      4'h0: begin
        b.fmt   = 3'd0;
        b.aluop = w[27:24];
        b.rd    = w[23:20];
        b.rm    = w[19:16];
        b.imm   = ext16(w[15:0]);
      end
      4'h1: begin
        b.fmt   = 3'd1;
        b.aluop = w[27:24];
        b.rd    = w[23:20];
        b.rm    = w[19:16];
        b.rn    = w[15:12];
        b.shift = w[11:7];
        b.ctl   = {5'b0, w[6:0]};
      end
      4'h2: begin
        b.fmt = 3'd2;
        b.ctl = {8'b0, w[27:24]};
        b.imm = ext24(w[23:0]);
      end
      4'h3: begin
        b.fmt   = 3'd3;
        b.aluop = w[27:24];
        b.rd    = w[23:20];
        b.rm    = w[19:16];
        b.rn    = w[15:12];
        b.ctl   = w[11:0];
      end
      4'h4: begin
        b.fmt   = 3'd4;
        b.ctl   = {8'b0, w[27:24]};
        b.rd    = w[23:20];
        b.aluop = w[19:16];
        b.imm   = ext16(w[15:0]);
      end
      default: begin
        b.fmt     = 3'd7;
        b.illegal = 1'b1;
      end
    endcase
    return b;
  endfunction

  bundle_t                mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [CNT_WIDTH-1:0]   ndec_q, ndec_d;
  logic                   push_en, pop_en;
  bundle_t                head;

  assign reqd    = (count_q < DEPTH_C);
  assign dvalid  = (count_q != '0);
  // Flush wins over both handshakes in the same cycle.
  assign push_en = ackd & reqd & ~flush;
  assign pop_en  = dvalid & dready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ndec_d   = ndec_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      ndec_d   = ndec_q + CNT_WIDTH'(1);
    end
    if (pop_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push_en && !pop_en) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_en && !push_en) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ndec_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ndec_q   <= ndec_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; stale entries are masked off by dvalid below.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= decode(instd);
  end

  assign head     = dvalid ? mem_q[rd_ptr_q] : '0;
  assign fmt      = head.fmt;
  assign aluop    = head.aluop;
  assign regdst   = head.rd;
  assign regsrc   = head.rm;
  assign regopd   = head.rn;
  assign shift    = head.shift;
  assign imm      = head.imm;
  assign ctlsig   = head.ctl;
  assign illegal  = head.illegal;
  assign ndecoded = ndec_q;

endmodule

// File: tb/tb_hs32_decode_q.sv
// Scoreboard bench for hs32_decode_q: a sign-extending and a zero-extending instance
// share stimulus; a word-level reference queue predicts the head of both.
module tb_hs32_decode_q;

  localparam int DEPTH = 2;
  localparam int CW    = 4;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [3:0]  aluop;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic [11:0] ctl;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instd = '0;
  logic        ackd = 1'b0, dready = 1'b0, flush = 1'b0;

  logic          reqd_a, dvalid_a, illegal_a, reqd_b, dvalid_b, illegal_b;
  logic [2:0]    fmt_a, fmt_b;
  logic [3:0]    aluop_a, regdst_a, regsrc_a, regopd_a;
  logic [3:0]    aluop_b, regdst_b, regsrc_b, regopd_b;
  logic [4:0]    shift_a, shift_b;
  logic [31:0]   imm_a, imm_b;
  logic [11:0]   ctlsig_a, ctlsig_b;
  logic [CW-1:0] nd_a, nd_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]   exp_q[$];
  logic [CW-1:0] exp_n = '0;

  always #5 clk = ~clk;

  hs32_decode_q #(.DEPTH(DEPTH), .IMM_SEXT(1'b1), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset(reset), .instd(instd), .ackd(ackd), .reqd(reqd_a),
    .flush(flush), .dvalid(dvalid_a), .dready(dready), .fmt(fmt_a),
    .aluop(aluop_a), .regdst(regdst_a), .regsrc(regsrc_a), .regopd(regopd_a),
    .shift(shift_a), .imm(imm_a), .ctlsig(ctlsig_a), .illegal(illegal_a),
    .ndecoded(nd_a)
  );

  hs32_decode_q #(.DEPTH(DEPTH), .IMM_SEXT(1'b0), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .reset(reset), .instd(instd), .ackd(ackd), .reqd(reqd_b),
    .flush(flush), .dvalid(dvalid_b), .dready(dready), .fmt(fmt_b),
    .aluop(aluop_b), .regdst(regdst_b), .regsrc(regsrc_b), .regopd(regopd_b),
    .shift(shift_b), .imm(imm_b), .ctlsig(ctlsig_b), .illegal(illegal_b),
    .ndecoded(nd_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Field extraction by shifting and masking, straight from the format table.
  function automatic exp_t ref_decode(input logic [31:0] w, input bit sext);
    exp_t e;
    logic [31:0] lo16, lo24;
    e    = '0;
    lo16 = (w & 32'h0000_FFFF) | ((sext && w[15]) ? 32'hFFFF_0000 : 32'h0);
    lo24 = (w & 32'h00FF_FFFF) | ((sext && w[23]) ? 32'hFF00_0000 : 32'h0);
    case (w >> 28)
      0: begin e.fmt = 0; e.aluop = 4'((w >> 24) & 15); e.rd = 4'((w >> 20) & 15);
               e.rm = 4'((w >> 16) & 15); e.imm = lo16; end
      1: begin e.fmt = 1; e.aluop = 4'((w >> 24) & 15); e.rd = 4'((w >> 20) & 15);
               e.rm = 4'((w >> 16) & 15); e.rn = 4'((w >> 12) & 15);
               e.shift = 5'((w >> 7) & 31); e.ctl = 12'(w & 127); end
      2: begin e.fmt = 2; e.ctl = 12'((w >> 24) & 15); e.imm = lo24; end
      3: begin e.fmt = 3; e.aluop = 4'((w >> 24) & 15); e.rd = 4'((w >> 20) & 15);
               e.rm = 4'((w >> 16) & 15); e.rn = 4'((w >> 12) & 15);
               e.ctl = 12'(w & 4095); end
      4: begin e.fmt = 4; e.ctl = 12'((w >> 24) & 15); e.rd = 4'((w >> 20) & 15);
               e.aluop = 4'((w >> 16) & 15); e.imm = lo16; end
      default: begin e.fmt = 7; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  // Reference queue: push side of the scoreboard, updated on every edge.
  initial begin : model
    bit full;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        exp_n = '0;
      end else if (flush) begin
        exp_q.delete();
      end else begin
        full = (exp_q.size() >= DEPTH);
        if (exp_q.size() != 0 && dready) void'(exp_q.pop_front());
        if (ackd && !full) begin
          exp_q.push_back(instd);
          exp_n = exp_n + 4'd1;
        end
      end
    end
  end

  // Monitor: compares the presented head of each instance with the reference head.
  initial begin : monitor
    exp_t ea, eb, act_a, act_b;
    forever begin
      @(negedge clk);
      ea = '0;
      eb = '0;
      if (exp_q.size() != 0) begin
        ea = ref_decode(exp_q[0], 1'b1);
        eb = ref_decode(exp_q[0], 1'b0);
      end
      act_a = {fmt_a, aluop_a, regdst_a, regsrc_a, regopd_a, shift_a, imm_a, ctlsig_a, illegal_a};
      act_b = {fmt_b, aluop_b, regdst_b, regsrc_b, regopd_b, shift_b, imm_b, ctlsig_b, illegal_b};
      check("dvalid_a", dvalid_a, exp_q.size() != 0);
      check("reqd_a", reqd_a, exp_q.size() < DEPTH);
      check("ndecoded_a", nd_a, exp_n);
      check("head_a", act_a, ea);
      check("dvalid_b", dvalid_b, exp_q.size() != 0);
      check("head_b", act_b, eb);
      check("ndecoded_b", nd_b, exp_n);
    end
  end

  task automatic step(input logic a, input logic [31:0] w, input logic r, input logic f);
    ackd   = a;
    instd  = w;
    dready = r;
    flush  = f;
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic [31:0] w;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_reqd", reqd_a, 1'b1);
    check("rst_dvalid", dvalid_a, 1'b0);
    check("rst_nd", nd_a, 4'd0);
    reset = 1'b0;

    step(1'b1, 32'h0123_8001, 1'b1, 1'b0);
    check("imm16_dvalid", dvalid_a, 1'b1);
    check("imm16_fields", {fmt_a, aluop_a, regdst_a, regsrc_a}, {3'd0, 4'd1, 4'd2, 4'd3});
    check("imm16_sext", imm_a, 32'hFFFF_8001);
    check("imm16_zext", imm_b, 32'h0000_8001);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h1A53_C5AB, 1'b1, 1'b0);
    check("shift_fields", {aluop_a, regdst_a, regsrc_a, regopd_a}, {4'hA, 4'd5, 4'd3, 4'hC});
    check("shift_amt", shift_a, 5'h0B);
    check("shift_ctl", ctlsig_a, 12'h02B);
    step(1'b1, 32'h4712_0010, 1'b1, 1'b0);
    check("jump_fields", {fmt_a, ctlsig_a, regdst_a, aluop_a}, {3'd4, 12'd7, 4'd1, 4'd2});
    check("jump_imm", imm_a, 32'h0000_0010);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h3111_1001, 1'b0, 1'b0);
    step(1'b1, 32'h3222_2002, 1'b0, 1'b0);
    check("full_reqd", reqd_a, 1'b0);
    step(1'b1, 32'h3333_3003, 1'b0, 1'b0);
    check("held_head", regdst_a, 4'd1);
    step(1'b1, 32'h3333_3003, 1'b1, 1'b0);
    check("pop_no_push_reqd", reqd_a, 1'b1);
    check("second_head", regdst_a, 4'd2);
    step(1'b1, 32'h3333_3003, 1'b1, 1'b0);
    check("third_head", regdst_a, 4'd3);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drained", dvalid_a, 1'b0);

    step(1'b1, 32'h9000_0000, 1'b0, 1'b0);
    check("illegal_flag", illegal_a, 1'b1);
    check("illegal_fmt", fmt_a, 3'd7);
    check("illegal_imm", imm_a, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h0AAA_0001, 1'b0, 1'b0);
    step(1'b1, 32'h0BBB_0002, 1'b0, 1'b0);
    step(1'b1, 32'h0CCC_0003, 1'b1, 1'b1);
    check("flush_dvalid", dvalid_a, 1'b0);
    check("flush_reqd", reqd_a, 1'b1);
    check("flush_imm", imm_a, 32'h0);
    step(1'b1, 32'h0DDD_0004, 1'b0, 1'b0);
    step(1'b1, 32'h0EEE_0005, 1'b1, 1'b1);
    check("flush1_dvalid", dvalid_a, 1'b0);

    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[31:28] = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) step(1'b1, 32'h2080_0000 + 32'(i), 1'b1, 1'b0);
    check("nd_before_wrap", nd_a, 4'hF);
    step(1'b1, 32'h2000_0010, 1'b1, 1'b0);
    check("nd_wrap", nd_a, 4'h0);
    check("wrap_imm24", imm_a, 32'h0000_0010);
    step(1'b1, 32'h2080_0001, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_dvalid", dvalid_a, 1'b0);
    check("midrst_reqd", reqd_a, 1'b1);
    check("midrst_nd", nd_a, 4'd0);
    check("midrst_imm", imm_a, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
